// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the FIFO write-port arbiter and the FIFO instance
// it feeds.
//   - arb_state_t    : arbiter FSM state encoding (IDLE / GRANT)
//   - DEF_FIFO_WIDTH : default FIFO data width
//   - DEF_NUM_REQ    : default number of producers
//   - first_set()    : first set bit of a vector, scanning upward from a
//                      start index with wrap-around
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;

    // Upper bound on producers; the scan function works on a vector this wide.
    localparam int MAX_NUM_REQ    = 8;

    // Returns the index of the first set bit in vec[width-1:0], starting the
    // scan at 'start' and wrapping past width-1 back to 0. If no bit is set
    // the start index is returned; callers qualify the result with |vec.
    function automatic int first_set(input logic [MAX_NUM_REQ-1:0] vec,
                                     input int start,
                                     input int width);
        logic [2:0] idx;
        logic       found;
        first_set = start;
        found     = 1'b0;
        for (int i = 0; i < MAX_NUM_REQ; i++) begin
            if (i < width) begin
                idx = 3'((start + i) % width);
                if (!found && vec[idx]) begin
                    first_set = int'(idx);
                    found     = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Picks the first asserted
// request strictly after the previously granted index, wrapping around.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_ptr   in  IDX_W    index granted most recently
//   sel_onehot out NUM_REQ  one-hot selection (zero when req is zero)
//   sel_idx    out IDX_W    binary index of the selection
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] sel_onehot,
    output logic [IDX_W-1:0]   sel_idx
);

    logic [MAX_NUM_REQ-1:0] req_ext;
    int                     start_idx;
    int                     pick;

    // Scan begins one past the last winner so the previous owner goes to
    // the back of the queue.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        start_idx            = (int'(last_ptr) + 1) % NUM_REQ;
        pick                 = first_set(req_ext, start_idx, NUM_REQ);
        sel_idx              = IDX_W'(pick);
        sel_onehot           = '0;
        if (|req) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one FIFO write port between NUM_REQ producers using round-robin
// arbitration with bursts bounded to MAX_BURST accepted words per grant.
// Every grant is followed by one IDLE (arbitration) cycle.
// Ports:
//   clk        in  1                   clock
//   rst        in  1                   asynchronous active-high reset
//   req        in  NUM_REQ             per-producer write request (level)
//   din        in  NUM_REQ*FIFO_WIDTH  packed producer data, i at [i*W +: W]
//   ack        out NUM_REQ             one-hot: producer word taken this edge
//   fifo_full  in  1                   FIFO full flag
//   fifo_din   out FIFO_WIDTH          FIFO write data
//   fifo_wen   out 1                   FIFO write enable
//   grant      out NUM_REQ             registered one-hot grant, 0 when idle
//   busy       out 1                   high while a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int MAX_BURST  = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic [FIFO_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wen,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [NUM_REQ-1:0]   acc;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     last_ptr;
    logic [IDX_W-1:0]     last_ptr_nxt;
    logic [CNT_W-1:0]     burst_cnt;
    logic [CNT_W-1:0]     burst_cnt_nxt;
    logic                 release_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_ptr   (last_ptr),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx)
    );

    // A word moves only when the owner requests and the FIFO has room.
    assign acc      = grant & req & {NUM_REQ{~fifo_full}};
    assign ack      = acc;
    assign fifo_wen = |acc;
    assign busy     = (state == GRANT);

    // Data mux keyed on the registered grant so it reads zero when idle.
    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fifo_din = din[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Next-state logic. While granted, last_ptr holds the owner's index,
    // so it doubles as the index of the current grant. Clearing the
    // counter on release keeps it at or below MAX_BURST-1.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_ptr_nxt  = last_ptr;
        burst_cnt_nxt = burst_cnt;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt     = GRANT;
                    grant_nxt     = sel_onehot;
                    last_ptr_nxt  = sel_idx;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (|acc) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
                release_grant = !req[last_ptr] ||
                                ((|acc) && (burst_cnt == CNT_W'(MAX_BURST - 1)));
                if (release_grant) begin
                    state_nxt     = IDLE;
                    grant_nxt     = '0;
                    burst_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State registers; reset leaves last_ptr on the top index so
    // producer 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            last_ptr  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
            last_ptr  <= last_ptr_nxt;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's FIFO (data in, write enable, full) between NUM_REQ producers.
- Uses round-robin arbitration with bounded bursts. A grant is held for up to MAX_BURST accepted words, then the port rotates to the next producer.
- Sits in the write-clock domain directly in front of the FIFO and drives its write data and write enable.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- FIFO_WIDTH, 16, data word width; must match the FIFO.
- MAX_BURST, 8, maximum accepted words per grant (1..255).
- CNT_W, 8, burst counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-producer write request; a level held while data is valid.
- din  input  NUM_REQ*FIFO_WIDTH  producer data, packed; producer i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- ack  output  NUM_REQ  one-hot; the word from producer i is accepted at this clock edge.
- fifo_full  input  1  FIFO full flag.
- fifo_din  output  FIFO_WIDTH  write data to the FIFO.
- fifo_wen  output  1  write enable to the FIFO.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when idle.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - state=IDLE, grant=0, burst_cnt=0, last_ptr=NUM_REQ-1 (so producer 0 wins first).
  - Outputs during reset: ack=0, fifo_wen=0, busy=0, fifo_din=0.
- Combinational outputs:
  - acc = grant & req & {NUM_REQ{~fifo_full}}.
  - ack = acc; fifo_wen = |acc.
  - fifo_din = din slice of the granted index, or 0 when grant=0.
- State IDLE:
  - If req≠0, select the first asserted req scanning from last_ptr+1 upward with wrap-around.
  - Next edge: grant ← onehot(sel), last_ptr ← sel, burst_cnt ← 0, state ← GRANT.
  - If req=0, remain in IDLE.
- State GRANT (idx = granted index):
  - Accepted word (acc≠0): burst_cnt ← burst_cnt+1.
  - Release condition: req[idx]=0, or (acc≠0 and burst_cnt==MAX_BURST-1).
  - On release: grant ← 0, state ← IDLE at that edge.
  - The minimum gap between grants is therefore one IDLE cycle (arbitration bubble).
- Latency: req rises before edge N → grant high after N → first word is written at edge N+1 if not full.
- Full handling:
  - While fifo_full=1: ack=0, fifo_wen=0, burst_cnt holds, grant holds.
  - There is no timeout; the producer may keep req high indefinitely.
- req[idx] dropping while fifo_full=1 still releases the grant.
- A word is never written without a matching ack pulse. A producer must hold din stable while req=1 and ack=0.
- Fairness:
  - A producer that requests continuously is granted within (NUM_REQ-1) bursts.
  - A lone requester is re-granted after each one-cycle bubble.
- grant is always one-hot or zero. Driving fifo_wen with fifo_full=1 is illegal; the bench asserts both properties.
- burst_cnt never exceeds MAX_BURST-1.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=1'b0, GRANT=1'b1);
  - the default constants FIFO_WIDTH=16 and NUM_REQ=4, shared with the FIFO instantiation;
  - a function returning the first set bit of a vector, scanning from a start index with wrap-around.
- One natural sub-module: rr_pick. It is purely combinational, takes req and last_ptr, and returns the one-hot selection plus its index. The FSM, counter and muxes stay in the top.

Test Plan:
- Reset priority: after reset, req=4'b1111 held, fifo_full=0 → grants appear in order 0,1,2,3,0. Each grant produces 8 acks, with exactly 1 idle cycle between grants.
- Short burst: req[2] high for 3 cycles only, carrying din values 0xA001..0xA003 → fifo_wen pulses 3 times, fifo_din = 0xA001, 0xA002, 0xA003. grant drops the edge after req[2] falls.
- Full stall: during a burst for producer 1, fifo_full=1 for 5 cycles after word 4 → ack=0 and fifo_wen=0 for 5 cycles, grant stays. The burst then resumes and ends after word 8.
- Wrap-around: last_ptr=3, req=4'b0101 → producer 0 granted, then producer 2, then producer 0.
- Async reset mid-burst: assert rst between edges after word 5 of producer 3 → grant, ack and fifo_wen go 0 immediately. After release with req=4'b1000, producer 3 is granted first.
- MAX_BURST=1 build, req=4'b0011 → grant alternates 0,1,0,1, each with one write and one bubble.
